mul_reservation_station: RTL and testbench
==========================================

Name: mul_reservation_station

Overview:
- Reservation station that sits directly upstream of the multiply functional unit, i.e. the pipelined multiplier together with its Idle/Mul32/…/MulAnswer state controller.
- Accepts issued multiply instructions whose operands are either values or producer tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Dispatches one operand-ready entry at a time to the multiplier, driving its enable and operand inputs plus the destination tag that travels with the result.

Parameters:
- ENTRIES, 3: number of station entries (1..8).
- DATA_W, 32: operand width.
- TAG_W, 4: tag width. Tag value 0 means "no pending producer".
- BASE_TAG, 4: tag of entry 0. Entry i owns tag BASE_TAG+i. Must be nonzero, and BASE_TAG+ENTRIES-1 < 2^TAG_W.

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one entry is free.
- issue_q1  in  TAG_W  producer tag of operand 1 (0 = issue_v1 valid).
- issue_v1  in  DATA_W  operand 1 value.
- issue_q2  in  TAG_W  producer tag of operand 2 (0 = issue_v2 valid).
- issue_v2  in  DATA_W  operand 2 value.
- issue_tag  out  TAG_W  tag of the entry that will be allocated this cycle (combinational).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB producer tag.
- cdb_data  in  DATA_W  CDB value.
- fu_ready  in  1  multiplier controller is in Idle, or in MulAnswer with its result accepted.
- fu_en  out  1  one-cycle dispatch pulse, connected to the multiplier EN and controller inEN.
- fu_a  out  DATA_W  operand 1 to the multiplier.
- fu_b  out  DATA_W  operand 2 to the multiplier.
- fu_tag  out  TAG_W  destination tag of the dispatched entry.
- busy_vec  out  ENTRIES  per-entry busy flags (debug/stall logic).

Behaviour:
- Entry state: busy, Q1, V1, Q2, V2. An entry is ready when busy && Q1==0 && Q2==0.

Reset:
- All busy=0, all Q=0, all V=0.
- fu_en=0, fu_a=0, fu_b=0, fu_tag=0.
- issue_ready=1, busy_vec=0.

Issue:
- issue_ready = any entry not busy.
- Allocation goes to the lowest-index free entry; issue_tag = BASE_TAG + that index.
- When all entries are busy, issue_ready=0 and issue_tag=0; issue_valid is ignored.
- On issue_valid && issue_ready, the entry becomes busy at the next clock edge.

Same-cycle CDB bypass at issue:
- If cdb_valid && issue_qN!=0 && cdb_tag==issue_qN, the entry stores QN=0 and VN=cdb_data.
- Otherwise it stores issue_qN and issue_vN.

CDB snoop:
- Every cycle, for every busy entry with QN!=0 && QN==cdb_tag && cdb_valid, set QN<=0 and VN<=cdb_data.
- Both operands may capture in the same cycle.

Dispatch:
- Condition: fu_ready && !fu_en && any entry ready (evaluated on registered state only).
- A newly issued entry is never dispatchable in its issue cycle, so minimum issue-to-fu_en latency is 1 cycle.
- Selection: lowest-index ready entry.
- At the next clock edge: fu_en<=1, fu_a<=V1, fu_b<=V2, fu_tag<=BASE_TAG+index, and the entry's busy<=0.
- fu_en is high for exactly one cycle. The !fu_en term blocks back-to-back dispatch while the controller leaves Idle.
- fu_a, fu_b and fu_tag hold their values until the next dispatch.

Simultaneous events:
- Dispatch and issue in the same cycle: the freed entry is not reusable until the following cycle, because allocation uses the pre-edge busy flags.
- CDB capture and dispatch of the same entry cannot coincide: dispatch requires Q1==Q2==0 already registered.

Reset mid-operation:
- All entries are dropped and fu_en clears immediately.
- An in-flight multiplier result is discarded by the owner of the multiplier reset.

Decomposition:
- Shared header (head.v): define NO_TAG (0), and the MUL station BASE_TAG / ENTRIES constants alongside the existing state encodings (sIdle, sMul32, sMulAnswer).
- One natural sub-module: rs_entry. It holds one entry's busy/Q/V registers, its issue-write and CDB-capture logic, and outputs ready. The top level instantiates it with generate and contains the priority allocator and dispatch selector.

Test Plan:
- Ready issue: issue q1=0 v1=6, q2=0 v2=7 with fu_ready=1 -> issue_tag=4; fu_en pulses 1 cycle later with fu_a=6, fu_b=7, fu_tag=4; busy_vec returns to 000.
- Dependency wake-up: issue q1=9 v2=3 (q2=0), then CDB tag=9 data=11 three cycles later -> fu_en in the cycle after capture with fu_a=11, fu_b=3.
- Issue-cycle bypass: issue q1=9 while cdb_valid tag=9 data=5 -> entry stored ready with V1=5; dispatched next cycle.
- Full station: hold fu_ready=0 and issue 3 entries -> issue_ready=0 and issue_tag=0; a 4th issue_valid is ignored; raise fu_ready -> entry 0 (tag 4) dispatched first, and issue_ready=1 the cycle after.
- Back-to-back blocking: two ready entries with fu_ready held high -> fu_en never high in consecutive cycles; dispatch order is tag 4 then tag 5.
- Async reset: drop nRST mid-run with 2 busy entries and fu_en=1 -> busy_vec=0, fu_en=0 and fu_a/fu_b/fu_tag=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mul_reservation_station_pkg.sv
// Shared definitions for the multiply reservation station and its neighbours.
//   NO_TAG            : tag value meaning "operand already holds a value"
//   MUL_RS_ENTRIES    : default number of station entries
//   MUL_RS_BASE_TAG   : tag owned by entry 0 (entry i owns BASE_TAG+i)
//   mul_state_t       : state encodings of the multiplier controller
package mul_reservation_station_pkg;

    localparam int NO_TAG          = 0;
    localparam int MUL_RS_ENTRIES  = 3;
    localparam int MUL_RS_BASE_TAG = 4;

    typedef enum logic [1:0] {
        sIdle      = 2'd0,
        sMul32     = 2'd1,
        sMulAnswer = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_reservation_station_rs_entry.sv
// One reservation-station entry: busy flag plus two (tag, value) operand slots.
// Ports:
//   clk, nRST             : clock, asynchronous active-low reset
//   alloc                 : write the issue operands into this (free) entry
//   clear                 : entry is being dispatched, release it
//   issue_q1/v1, q2/v2    : operand tags/values from the issue stage
//   cdb_valid/tag/data    : common data bus broadcast
//   busy, ready           : entry occupied / occupied with both operands resolved
//   v1, v2                : stored operand values
module rs_entry
    import mul_reservation_station_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              alloc,
    input  logic              clear,
    input  logic [TAG_W-1:0]  issue_q1,
    input  logic [DATA_W-1:0] issue_v1,
    input  logic [TAG_W-1:0]  issue_q2,
    input  logic [DATA_W-1:0] issue_v2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] v1,
    output logic [DATA_W-1:0] v2
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(NO_TAG);

    logic              busy_reg;
    logic [TAG_W-1:0]  q1_reg;
    logic [TAG_W-1:0]  q2_reg;
    logic [DATA_W-1:0] v1_reg;
    logic [DATA_W-1:0] v2_reg;

    // Operand produced on the CDB in the very cycle it is issued.
    logic bypass1, bypass2;
    // Pending operand of a resident entry produced on the CDB this cycle.
    logic snoop1, snoop2;

    assign bypass1 = cdb_valid && (issue_q1 != NONE) && (cdb_tag == issue_q1);
    assign bypass2 = cdb_valid && (issue_q2 != NONE) && (cdb_tag == issue_q2);
    assign snoop1  = busy_reg && cdb_valid && (q1_reg != NONE) && (cdb_tag == q1_reg);
    assign snoop2  = busy_reg && cdb_valid && (q2_reg != NONE) && (cdb_tag == q2_reg);

    // alloc only targets a free entry and clear only a busy one, so they
    // never coincide.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_reg <= 1'b0;
            q1_reg   <= '0;
            q2_reg   <= '0;
            v1_reg   <= '0;
            v2_reg   <= '0;
        end else if (alloc) begin
            busy_reg <= 1'b1;
            q1_reg   <= bypass1 ? NONE     : issue_q1;
            v1_reg   <= bypass1 ? cdb_data : issue_v1;
            q2_reg   <= bypass2 ? NONE     : issue_q2;
            v2_reg   <= bypass2 ? cdb_data : issue_v2;
        end else begin
            if (clear) begin
                busy_reg <= 1'b0;
            end
            if (snoop1) begin
                q1_reg <= NONE;
                v1_reg <= cdb_data;
            end
            if (snoop2) begin
                q2_reg <= NONE;
                v2_reg <= cdb_data;
            end
        end
    end

    assign busy  = busy_reg;
    assign ready = busy_reg && (q1_reg == NONE) && (q2_reg == NONE);
    assign v1    = v1_reg;
    assign v2    = v2_reg;

endmodule

// File: rtl/mul_reservation_station.sv
// Reservation station in front of the pipelined multiplier.
// Holds issued multiply instructions until both operands are known (snooping
// the CDB), then dispatches the lowest-index ready entry with a one-cycle
// fu_en pulse.
// Ports:
//   clk, nRST                     : clock, asynchronous active-low reset
//   issue_valid/ready/tag         : issue handshake; issue_tag is the entry
//                                   that would be allocated this cycle (0 when full)
//   issue_q1/v1, issue_q2/v2      : operand tags (0 = value valid) and values
//   cdb_valid/tag/data            : common data bus broadcast
//   fu_ready                      : multiplier controller can accept an operation
//   fu_en, fu_a, fu_b, fu_tag     : registered dispatch pulse, operands, dest tag
//   busy_vec                      : per-entry busy flags
module mul_reservation_station
    import mul_reservation_station_pkg::*;
#(
    parameter int ENTRIES  = MUL_RS_ENTRIES,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int BASE_TAG = MUL_RS_BASE_TAG
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [TAG_W-1:0]   issue_q1,
    input  logic [DATA_W-1:0]  issue_v1,
    input  logic [TAG_W-1:0]   issue_q2,
    input  logic [DATA_W-1:0]  issue_v2,
    output logic [TAG_W-1:0]   issue_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    input  logic               fu_ready,
    output logic               fu_en,
    output logic [DATA_W-1:0]  fu_a,
    output logic [DATA_W-1:0]  fu_b,
    output logic [TAG_W-1:0]   fu_tag,
    output logic [ENTRIES-1:0] busy_vec
);

    logic [ENTRIES-1:0] ready_vec;
    logic [ENTRIES-1:0] alloc_sel;
    logic [ENTRIES-1:0] disp_sel;
    logic [DATA_W-1:0]  v1_arr [ENTRIES];
    logic [DATA_W-1:0]  v2_arr [ENTRIES];

    logic               any_free;
    logic [TAG_W-1:0]   alloc_tag;
    logic               any_ready;
    logic [DATA_W-1:0]  disp_a;
    logic [DATA_W-1:0]  disp_b;
    logic [TAG_W-1:0]   disp_tag;
    logic               do_issue;
    logic               dispatch;

    // Priority allocator and dispatch selector. Scanning from the top index
    // down lets the lowest matching index win.
    always_comb begin
        alloc_sel = '0;
        alloc_tag = '0;
        any_free  = 1'b0;
        disp_sel  = '0;
        disp_a    = '0;
        disp_b    = '0;
        disp_tag  = '0;
        any_ready = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                alloc_sel    = '0;
                alloc_sel[i] = 1'b1;
                alloc_tag    = TAG_W'(BASE_TAG + i);
                any_free     = 1'b1;
            end
            if (ready_vec[i]) begin
                disp_sel    = '0;
                disp_sel[i] = 1'b1;
                disp_a      = v1_arr[i];
                disp_b      = v2_arr[i];
                disp_tag    = TAG_W'(BASE_TAG + i);
                any_ready   = 1'b1;
            end
        end
    end

    assign issue_ready = any_free;
    assign issue_tag   = alloc_tag;
    assign do_issue    = issue_valid && any_free;
    // !fu_en keeps a second dispatch from landing while the controller is
    // still leaving Idle after the previous pulse.
    assign dispatch    = fu_ready && !fu_en && any_ready;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            rs_entry #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W)
            ) u_entry (
                .clk       (clk),
                .nRST      (nRST),
                .alloc     (do_issue && alloc_sel[gi]),
                .clear     (dispatch && disp_sel[gi]),
                .issue_q1  (issue_q1),
                .issue_v1  (issue_v1),
                .issue_q2  (issue_q2),
                .issue_v2  (issue_v2),
                .cdb_valid (cdb_valid),
                .cdb_tag   (cdb_tag),
                .cdb_data  (cdb_data),
                .busy      (busy_vec[gi]),
                .ready     (ready_vec[gi]),
                .v1        (v1_arr[gi]),
                .v2        (v2_arr[gi])
            );
        end
    endgenerate

    // Dispatch outputs hold their last values between pulses.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            fu_en  <= 1'b0;
            fu_a   <= '0;
            fu_b   <= '0;
            fu_tag <= '0;
        end else begin
            fu_en <= dispatch;
            if (dispatch) begin
                fu_a   <= disp_a;
                fu_b   <= disp_b;
                fu_tag <= disp_tag;
            end
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
module tb_mul_reservation_station;

    localparam int ENTRIES  = 3;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int BASE_TAG = 4;

    logic               clk = 1'b0;
    logic               nRST;
    logic               issue_valid;
    logic               issue_ready;
    logic [TAG_W-1:0]   issue_q1;
    logic [DATA_W-1:0]  issue_v1;
    logic [TAG_W-1:0]   issue_q2;
    logic [DATA_W-1:0]  issue_v2;
    logic [TAG_W-1:0]   issue_tag;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]  cdb_data;
    logic               fu_ready;
    logic               fu_en;
    logic [DATA_W-1:0]  fu_a;
    logic [DATA_W-1:0]  fu_b;
    logic [TAG_W-1:0]   fu_tag;
    logic [ENTRIES-1:0] busy_vec;

    mul_reservation_station #(
        .ENTRIES  (ENTRIES),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .BASE_TAG (BASE_TAG)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_q1    (issue_q1),
        .issue_v1    (issue_v1),
        .issue_q2    (issue_q2),
        .issue_v2    (issue_v2),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_ready    (fu_ready),
        .fu_en       (fu_en),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_tag      (fu_tag),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } disp_t;

    disp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model: a table of waiting instructions.
    bit                m_busy [ENTRIES];
    logic [TAG_W-1:0]  m_q1   [ENTRIES];
    logic [TAG_W-1:0]  m_q2   [ENTRIES];
    logic [DATA_W-1:0] m_v1   [ENTRIES];
    logic [DATA_W-1:0] m_v2   [ENTRIES];
    bit                m_fu_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_busy[i] = 1'b0;
            m_q1[i]   = '0;
            m_q2[i]   = '0;
            m_v1[i]   = '0;
            m_v2[i]   = '0;
        end
        m_fu_en = 1'b0;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check the
    // combinational outputs against the model, advance the model, and queue
    // any dispatch the model predicts for the coming rising edge.
    task automatic step(input bit iv, input logic [TAG_W-1:0] q1, input logic [DATA_W-1:0] v1,
                        input logic [TAG_W-1:0] q2, input logic [DATA_W-1:0] v2,
                        input bit cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
                        input bit fr);
        int free;
        int disp;
        logic [ENTRIES-1:0] exp_busy;
        @(negedge clk);
        issue_valid = iv; issue_q1 = q1; issue_v1 = v1; issue_q2 = q2; issue_v2 = v2;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd; fu_ready = fr;
        #1;
        free = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) if (!m_busy[i]) free = i;
        for (int i = 0; i < ENTRIES; i++) exp_busy[i] = m_busy[i];
        check("busy_vec", 64'(busy_vec), 64'(exp_busy));
        check("issue_ready", 64'(issue_ready), 64'(free >= 0));
        check("issue_tag", 64'(issue_tag), (free >= 0) ? 64'(BASE_TAG + free) : 64'd0);

        disp = -1;
        if (fr && !m_fu_en)
            for (int i = ENTRIES - 1; i >= 0; i--)
                if (m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) disp = i;
        if (disp >= 0) exp_q.push_back('{m_v1[disp], m_v2[disp], TAG_W'(BASE_TAG + disp)});

        for (int i = 0; i < ENTRIES; i++) begin
            if (m_busy[i] && cv) begin
                if (m_q1[i] != 0 && m_q1[i] == ct) begin m_q1[i] = '0; m_v1[i] = cd; end
                if (m_q2[i] != 0 && m_q2[i] == ct) begin m_q2[i] = '0; m_v2[i] = cd; end
            end
        end
        if (disp >= 0) m_busy[disp] = 1'b0;
        if (iv && free >= 0) begin
            m_busy[free] = 1'b1;
            if (cv && q1 != 0 && q1 == ct) begin m_q1[free] = '0; m_v1[free] = cd; end
            else begin m_q1[free] = q1; m_v1[free] = v1; end
            if (cv && q2 != 0 && q2 == ct) begin m_q2[free] = '0; m_v2[free] = cd; end
            else begin m_q2[free] = q2; m_v2[free] = v2; end
        end
        m_fu_en = (disp >= 0);
        @(posedge clk);
    endtask

    task automatic idle(input bit fr);
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, fr);
    endtask

    // Scoreboard monitor: compares every dispatch pulse with the queue head
    // and checks that the dispatch outputs hold between pulses.
    task automatic monitor();
        disp_t e;
        logic [DATA_W-1:0] hold_a = '0;
        logic [DATA_W-1:0] hold_b = '0;
        logic [TAG_W-1:0]  hold_t = '0;
        bit prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!nRST) begin
                exp_q.delete();
                hold_a = '0; hold_b = '0; hold_t = '0; prev_en = 1'b0;
            end else begin
                if (fu_en) begin
                    check("fu_en_back_to_back", 64'(prev_en), 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dispatch: got fu_tag=%0h expected no dispatch", fu_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("fu_a", 64'(fu_a), 64'(e.a));
                        check("fu_b", 64'(fu_b), 64'(e.b));
                        check("fu_tag", 64'(fu_tag), 64'(e.tag));
                        $display("dispatch tag=%0d a=%0h b=%0h", fu_tag, fu_a, fu_b);
                    end
                    hold_a = fu_a; hold_b = fu_b; hold_t = fu_tag;
                end else begin
                    check("fu_a_hold", 64'(fu_a), 64'(hold_a));
                    check("fu_b_hold", 64'(fu_b), 64'(hold_b));
                    check("fu_tag_hold", 64'(fu_tag), 64'(hold_t));
                end
                prev_en = fu_en;
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        issue_valid = 0; issue_q1 = '0; issue_v1 = '0; issue_q2 = '0; issue_v2 = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; fu_ready = 0;
        model_reset();
        fork
            monitor();
        join_none
        #1;
        check("rst_busy_vec", 64'(busy_vec), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_issue_tag", 64'(issue_tag), 64'd4);
        check("rst_fu_en", 64'(fu_en), 64'd0);
        check("rst_fu_a", 64'(fu_a), 64'd0);
        check("rst_fu_b", 64'(fu_b), 64'd0);
        check("rst_fu_tag", 64'(fu_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 nRST = 1'b1;

        // Ready issue: dispatched one cycle after issue.
        step(1, 4'd0, 32'd6, 4'd0, 32'd7, 0, 4'd0, 32'd0, 1);
        idle(1);
        #1;
        check("ready_fu_en", 64'(fu_en), 64'd1);
        check("ready_fu_a", 64'(fu_a), 64'd6);
        check("ready_fu_b", 64'(fu_b), 64'd7);
        check("ready_fu_tag", 64'(fu_tag), 64'd4);
        check("ready_busy_vec", 64'(busy_vec), 64'd0);
        idle(1);

        // Dependency wake-up via CDB three cycles after issue.
        step(1, 4'd9, 32'd0, 4'd0, 32'd3, 0, 4'd0, 32'd0, 1);
        idle(1);
        idle(1);
        step(0, 4'd0, 32'd0, 4'd0, 32'd0, 1, 4'd9, 32'd11, 1);
        idle(1);
        #1;
        check("wake_fu_en", 64'(fu_en), 64'd1);
        check("wake_fu_a", 64'(fu_a), 64'd11);
        check("wake_fu_b", 64'(fu_b), 64'd3);
        idle(1);

        // Issue-cycle bypass.
        step(1, 4'd9, 32'd0, 4'd0, 32'd8, 1, 4'd9, 32'd5, 1);
        idle(1);
        #1;
        check("bypass_fu_en", 64'(fu_en), 64'd1);
        check("bypass_fu_a", 64'(fu_a), 64'd5);
        idle(1);

        // Full station: fourth issue ignored, entry 0 dispatched first.
        for (int k = 0; k < 3; k++) step(1, 4'd0, 32'(10 + k), 4'd0, 32'(20 + k), 0, 4'd0, 32'd0, 0);
        step(1, 4'd0, 32'd99, 4'd0, 32'd98, 0, 4'd0, 32'd0, 0);
        #1;
        check("full_issue_ready", 64'(issue_ready), 64'd0);
        check("full_issue_tag", 64'(issue_tag), 64'd0);
        check("full_busy_vec", 64'(busy_vec), 64'b111);
        idle(1);
        #1;
        check("full_first_tag", 64'(fu_tag), 64'd4);
        check("full_issue_ready_after", 64'(issue_ready), 64'd1);
        for (int k = 0; k < 5; k++) idle(1);

        // Back-to-back blocking: two ready entries, fu_ready held high.
        step(1, 4'd0, 32'd1, 4'd0, 32'd2, 0, 4'd0, 32'd0, 0);
        step(1, 4'd0, 32'd3, 4'd0, 32'd4, 0, 4'd0, 32'd0, 0);
        idle(1);
        #1;
        check("b2b_first_en", 64'(fu_en), 64'd1);
        check("b2b_first_tag", 64'(fu_tag), 64'd4);
        idle(1);
        #1;
        check("b2b_gap_en", 64'(fu_en), 64'd0);
        idle(1);
        #1;
        check("b2b_second_en", 64'(fu_en), 64'd1);
        check("b2b_second_tag", 64'(fu_tag), 64'd5);
        for (int k = 0; k < 3; k++) idle(1);

        // Asynchronous reset with two busy entries and fu_en high.
        step(1, 4'd0, 32'd2, 4'd0, 32'd3, 0, 4'd0, 32'd0, 0);
        step(1, 4'd9, 32'd0, 4'd0, 32'd1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd9, 32'd0, 4'd0, 32'd1, 0, 4'd0, 32'd0, 0);
        idle(1);
        #1;
        check("prerst_fu_en", 64'(fu_en), 64'd1);
        check("prerst_busy_vec", 64'(busy_vec), 64'b110);
        #1 nRST = 1'b0;
        #1;
        check("arst_busy_vec", 64'(busy_vec), 64'd0);
        check("arst_fu_en", 64'(fu_en), 64'd0);
        check("arst_fu_a", 64'(fu_a), 64'd0);
        check("arst_fu_b", 64'(fu_b), 64'd0);
        check("arst_fu_tag", 64'(fu_tag), 64'd0);
        check("arst_issue_ready", 64'(issue_ready), 64'd1);
        model_reset();
        @(negedge clk);
        #2 nRST = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            logic [TAG_W-1:0] rq1, rq2, rct;
            rq1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
            rq2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
            rct = 4'($urandom_range(1, 9));
            step($urandom_range(0, 1) == 1, rq1, $urandom, rq2, $urandom,
                 $urandom_range(0, 9) < 4, rct, $urandom, $urandom_range(0, 9) < 7);
        end

        // Drain: broadcast every producer tag, then let everything dispatch.
        for (int t = 1; t <= 9; t++) step(0, 4'd0, 32'd0, 4'd0, 32'd0, 1, 4'(t), $urandom, 1);
        for (int k = 0; k < 10; k++) idle(1);
        @(negedge clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_busy_vec", 64'(busy_vec), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
